// File: rtl/i2c_bit_sequencer.sv
// rtl/i2c_bit_sequencer.sv - bit-level I2C master sequencer (START/STOP/WRITE/READ)
// Each command is four quarter-bit phases of qtr_div+1 cycles, with SCL stretch and arbitration checks.
module i2c_bit_sequencer #(
  parameter int DIV_W = 16
) (
  input  logic             i_sys_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd,
  input  logic             i_cmd_wbit,
  input  logic [DIV_W-1:0] i_qtr_div,
  input  logic             i_scl_in,
  input  logic             i_sda_in,
  output logic             o_scl_oe,
  output logic             o_sda_oe,
  output logic             o_rsp_valid,
  output logic             o_rsp_rbit,
  output logic             o_arb_lost,
  output logic             o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_PA, S_PB, S_PC, S_PD} state_t;

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_READ  = 2'd3;

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_cmd;
  logic             r_wbit;
  logic             r_scl_oe;
  logic             r_sda_oe;
  logic             r_rsp_valid;
  logic             r_rsp_rbit;
  logic             r_arb_lost;
  logic             r_rbit_cap;

  state_t           w_state_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [1:0]       w_cmd_nxt;
  logic             w_wbit_nxt;
  logic [1:0]       w_oe_nxt;
  logic             w_rsp_nxt;
  logic             w_rbit_nxt;
  logic             w_arb_nxt;
  logic             w_cap_nxt;
  logic             w_arb_cond;

  // {scl_oe, sda_oe} for a given phase of a command; 1 pulls the line low
  function automatic logic [1:0] drive(input state_t ph, input logic [1:0] c, input logic w);
    logic [1:0] d;
    d = 2'b00;
    case (c)
      C_START: begin
        if (ph == S_PC)      d = 2'b01;
        else if (ph == S_PD) d = 2'b11;
        else                 d = 2'b00;
      end
      C_STOP: begin
        if (ph == S_PA)      d = 2'b11;
        else if (ph == S_PD) d = 2'b00;
        else                 d = 2'b01;
      end
      C_WRITE: d = {(ph == S_PA) || (ph == S_PD), ~w};
      default: d = {(ph == S_PA) || (ph == S_PD), 1'b0};
    endcase
    return d;
  endfunction

  // Only commands that release SDA high can lose arbitration to another master pulling low
  assign w_arb_cond = ((r_cmd == C_START) || ((r_cmd == C_WRITE) && r_wbit)) && !i_sda_in;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_cmd_nxt   = r_cmd;
    w_wbit_nxt  = r_wbit;
    w_oe_nxt    = {r_scl_oe, r_sda_oe};
    w_rsp_nxt   = 1'b0;
    w_rbit_nxt  = 1'b0;
    w_arb_nxt   = 1'b0;
    w_cap_nxt   = r_rbit_cap;
    if (r_state == S_IDLE) begin
      if (i_cmd_valid) begin
        w_state_nxt = S_PA;
        w_cnt_nxt   = i_qtr_div;
        w_div_nxt   = i_qtr_div;
        w_cmd_nxt   = i_cmd;
        w_wbit_nxt  = i_cmd_wbit;
        w_oe_nxt    = drive(S_PA, i_cmd, i_cmd_wbit);
      end
    end else if ((r_state == S_PB) && !i_scl_in) begin
      w_cnt_nxt = r_div;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - DIV_W'(1);
    end else begin
      w_cnt_nxt = r_div;
      case (r_state)
        S_PA: begin
          w_state_nxt = S_PB;
          w_oe_nxt    = drive(S_PB, r_cmd, r_wbit);
        end
        S_PB: begin
          w_state_nxt = S_PC;
          w_oe_nxt    = drive(S_PC, r_cmd, r_wbit);
        end
        S_PC: begin
          w_cap_nxt = i_sda_in;
          if (w_arb_cond) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 2'b00;
            w_arb_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_PD;
            w_oe_nxt    = drive(S_PD, r_cmd, r_wbit);
          end
        end
        S_PD: begin
          w_state_nxt = S_IDLE;
          w_rsp_nxt   = 1'b1;
          w_rbit_nxt  = (r_cmd == C_READ) && r_rbit_cap;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div       <= '0;
      r_cmd       <= 2'b00;
      r_wbit      <= 1'b0;
      r_scl_oe    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rbit  <= 1'b0;
      r_arb_lost  <= 1'b0;
      r_rbit_cap  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div       <= w_div_nxt;
      r_cmd       <= w_cmd_nxt;
      r_wbit      <= w_wbit_nxt;
      r_scl_oe    <= w_oe_nxt[1];
      r_sda_oe    <= w_oe_nxt[0];
      r_rsp_valid <= w_rsp_nxt;
      r_rsp_rbit  <= w_rbit_nxt;
      r_arb_lost  <= w_arb_nxt;
      r_rbit_cap  <= w_cap_nxt;
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_scl_oe    = r_scl_oe;
  assign o_sda_oe    = r_sda_oe;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rbit  = r_rsp_rbit;
  assign o_arb_lost  = r_arb_lost;

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// tb/tb_i2c_bit_sequencer.sv - directed self-checking bench for i2c_bit_sequencer
module tb_i2c_bit_sequencer;

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_READ  = 2'd3;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd;
  logic        cmd_wbit;
  logic [15:0] qtr_div;
  logic        scl_in;
  logic        sda_in;
  logic        sda_drv;
  logic        mirror;
  logic        scl_oe;
  logic        sda_oe;
  logic        rsp_valid;
  logic        rsp_rbit;
  logic        arb_lost;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  assign sda_in = mirror ? ~sda_oe : sda_drv;

  i2c_bit_sequencer #(.DIV_W(16)) dut (
    .i_sys_clk   (clk),
    .i_reset     (reset),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd       (cmd),
    .i_cmd_wbit  (cmd_wbit),
    .i_qtr_div   (qtr_div),
    .i_scl_in    (scl_in),
    .i_sda_in    (sda_in),
    .o_scl_oe    (scl_oe),
    .o_sda_oe    (sda_oe),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rbit  (rsp_rbit),
    .o_arb_lost  (arb_lost),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // pat = {PA, PB, PC, PD}, each {scl_oe, sda_oe}; returns in the rsp_valid cycle
  task automatic run_cmd(input logic [1:0] c, input logic w, input logic [15:0] d,
                         input logic [7:0] pat, input logic exp_rbit, input string tag);
    int len;
    int ph;
    len = int'(d) + 1;
    cmd = c;
    cmd_wbit = w;
    qtr_div = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4 * len; i++) begin
      ph = i / len;
      chk({tag, "_phase"}, {3'b000, scl_oe, sda_oe, rsp_valid, arb_lost, busy},
          {3'b000, pat[7-2*ph -: 2], 3'b001});
      tick();
    end
    chk({tag, "_rsp"}, {2'b00, rsp_valid, rsp_rbit, arb_lost, cmd_ready, scl_oe, sda_oe},
        {2'b00, 1'b1, exp_rbit, 1'b0, 1'b1, pat[1:0]});
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd = C_START;
    cmd_wbit = 1'b0;
    qtr_div = 16'd0;
    scl_in = 1'b1;
    sda_drv = 1'b1;
    mirror = 1'b0;
    tick();
    tick();
    chk("reset_state", {1'b0, scl_oe, sda_oe, rsp_valid, rsp_rbit, arb_lost, cmd_ready, busy},
        8'b00000010);
    reset = 1'b0;
    tick();

    // 1: START, 4-cycle phases, SCL held low afterwards
    run_cmd(C_START, 1'b0, 16'd3, 8'b00000111, 1'b0, "t1_start");
    tick();
    chk("t1_idle_hold", {5'b0, scl_oe, rsp_valid, cmd_ready}, {5'b0, 3'b101});

    // 2: back-to-back WRITE 0 / WRITE 1 with SDA mirroring the driver
    mirror = 1'b1;
    run_cmd(C_WRITE, 1'b0, 16'd1, 8'b11010111, 1'b0, "t2_w0");
    run_cmd(C_WRITE, 1'b1, 16'd1, 8'b10000010, 1'b0, "t2_w1");
    tick();
    chk("t2_after", {6'b0, rsp_valid, arb_lost}, 8'b0);

    // 3: READ returns the sampled SDA level; qtr_div=0 gives single-cycle phases
    mirror = 1'b0;
    sda_drv = 1'b1;
    run_cmd(C_READ, 1'b0, 16'd2, 8'b10000010, 1'b1, "t3_read1");
    sda_drv = 1'b0;
    run_cmd(C_READ, 1'b0, 16'd0, 8'b10000010, 1'b0, "t3_read0");
    sda_drv = 1'b1;
    tick();

    // 4: clock stretch of 10 cycles in PB; extra cmd_valid while busy is ignored
    mirror = 1'b1;
    cmd = C_WRITE;
    cmd_wbit = 1'b1;
    qtr_div = 16'd3;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      scl_in = (n >= 5 && n <= 14) ? 1'b0 : 1'b1;
      cmd_valid = (n >= 8 && n <= 20);
      cmd = C_STOP;
      chk("t4_stretch", {5'b0, scl_oe, rsp_valid, busy}, {5'b0, (n <= 4 || n >= 23), 2'b01});
      tick();
    end
    scl_in = 1'b1;
    cmd_valid = 1'b0;
    chk("t4_rsp", {5'b0, rsp_valid, arb_lost, cmd_ready}, 8'b00000101);

    // 5: WRITE 1 against a bus held low -> arbitration lost after PC
    mirror = 1'b0;
    sda_drv = 1'b0;
    cmd = C_WRITE;
    cmd_wbit = 1'b1;
    qtr_div = 16'd1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      chk("t5_pre", {3'b0, scl_oe, sda_oe, rsp_valid, arb_lost, busy},
          {3'b0, (n <= 2), 1'b0, 3'b001});
      tick();
    end
    chk("t5_arb", {2'b0, arb_lost, rsp_valid, scl_oe, sda_oe, cmd_ready, busy}, 8'b00100010);
    tick();
    chk("t5_after", {5'b0, arb_lost, rsp_valid, cmd_ready}, 8'b00000001);
    sda_drv = 1'b1;

    // 6: reset during STOP drops the command; a fresh START then runs normally
    cmd = C_STOP;
    cmd_wbit = 1'b0;
    qtr_div = 16'd3;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      chk("t6_stop", {6'b0, scl_oe, sda_oe}, {6'b0, (n <= 4), 1'b1});
      if (n < 5) tick();
    end
    reset = 1'b1;
    tick();
    chk("t6_reset", {1'b0, scl_oe, sda_oe, rsp_valid, rsp_rbit, arb_lost, cmd_ready, busy},
        8'b00000010);
    reset = 1'b0;
    tick();
    tick();
    chk("t6_idle", {5'b0, rsp_valid, arb_lost, busy}, 8'b0);
    run_cmd(C_START, 1'b0, 16'd0, 8'b00000111, 1'b0, "t6_start");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
